// File: rtl/alu_arbiter_if.sv
// Shared-ALU arbiter bus: requester request/response channels plus the ALU-side operand/result port.
// ALU_ARB_LOCK_EN adds the per-requester req_lock input.
package alu_pkg;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } aluop_t;
endpackage

interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  alu_pkg::aluop_t                    req_aluop [NUM_REQ];
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_opr_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_opr_b;
`ifdef ALU_ARB_LOCK_EN
  logic [NUM_REQ-1:0]                 req_lock;
`endif
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [NUM_REQ-1:0]                 resp_ready;
  logic [DATA_WIDTH-1:0]              resp_data;
  alu_pkg::aluop_t                    alu_aluop;
  logic [DATA_WIDTH-1:0]              alu_opr_a;
  logic [DATA_WIDTH-1:0]              alu_opr_b;
  logic [DATA_WIDTH-1:0]              alu_result;

`ifdef ALU_ARB_LOCK_EN
  modport slave (
    input  req_valid, req_aluop, req_opr_a, req_opr_b, req_lock, resp_ready, alu_result,
    output req_ready, resp_valid, resp_data, alu_aluop, alu_opr_a, alu_opr_b
  );
  modport master (
    output req_valid, req_aluop, req_opr_a, req_opr_b, req_lock, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_data, alu_aluop, alu_opr_a, alu_opr_b
  );
`else
  modport slave (
    input  req_valid, req_aluop, req_opr_a, req_opr_b, resp_ready, alu_result,
    output req_ready, resp_valid, resp_data, alu_aluop, alu_opr_a, alu_opr_b
  );
  modport master (
    output req_valid, req_aluop, req_opr_a, req_opr_b, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_data, alu_aluop, alu_opr_a, alu_opr_b
  );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters, one-entry tagged response slot.
// ALU_ARB_LOCK_EN: a locked transfer keeps the pointer on the winner for atomic back-to-back ops.

// Per-requester decode of the shared grant / response owner.
module alu_arbiter_lane #(
  parameter int IDX_W = 1,
  parameter int LANE  = 0
)(
  input  logic             gnt_vld,
  input  logic [IDX_W-1:0] gnt_idx,
  input  logic             full,
  input  logic [IDX_W-1:0] owner,
  input  logic             resp_rdy,
  output logic             ready,
  output logic             resp_vld,
  output logic             drain
);
  localparam logic [IDX_W-1:0] ID = IDX_W'(LANE);

  assign ready    = gnt_vld & (gnt_idx == ID);
  assign resp_vld = full & (owner == ID);
  // Only the owner's resp_ready can drain the slot.
  assign drain    = resp_vld & resp_rdy;
endmodule

module alu_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 2,
  localparam int IDX_W      = $clog2(NUM_REQ)
)(
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      owner;
  logic                  full;
  logic [DATA_WIDTH-1:0] data;

  logic                  gnt_vld;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      nxt_ptr;
  logic                  free;
  logic                  drain;
  logic [NUM_REQ-1:0]    lane_rdy;
  logic [NUM_REQ-1:0]    lane_rv;
  logic [NUM_REQ-1:0]    lane_drn;

  // Modulo-NUM_REQ add; operands stay below 2*NUM_REQ so one subtraction suffices.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  assign drain = |lane_drn;
  assign free  = !full | drain;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && bus.req_valid[wrap_add(ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_add(ptr, k);
      end
    end
    if (rst || !free) begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  assign nxt_ptr = bus.req_lock[gnt_idx] ? gnt_idx : wrap_add(gnt_idx, 1);
`else
  assign nxt_ptr = wrap_add(gnt_idx, 1);
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    alu_arbiter_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
      .gnt_vld  (gnt_vld),
      .gnt_idx  (gnt_idx),
      .full     (full),
      .owner    (owner),
      .resp_rdy (bus.resp_ready[i]),
      .ready    (lane_rdy[i]),
      .resp_vld (lane_rv[i]),
      .drain    (lane_drn[i])
    );
  end

  assign bus.req_ready  = lane_rdy;
  assign bus.resp_valid = lane_rv;
  assign bus.resp_data  = data;

  // Idle ALU sees ADD 0+0 so nothing undefined reaches it.
  assign bus.alu_aluop = gnt_vld ? bus.req_aluop[gnt_idx] : alu_pkg::ADD;
  assign bus.alu_opr_a = gnt_vld ? bus.req_opr_a[gnt_idx] : '0;
  assign bus.alu_opr_b = gnt_vld ? bus.req_opr_b[gnt_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      owner <= '0;
      full  <= 1'b0;
      data  <= '0;
    end else if (gnt_vld) begin
      full  <= 1'b1;
      owner <= gnt_idx;
      data  <= bus.alu_result;
      ptr   <= nxt_ptr;
    end else if (drain) begin
      full  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NUM_REQ=3): directed scenarios then randomized traffic vs a behavioural model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [DW-1:0] alu_f(input aluop_t op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      SLL:     return a << b[4:0];
      SRL:     return a >> b[4:0];
      SRA:     return $signed(a) >>> b[4:0];
      SLT:     return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      SLTU:    return (a < b) ? DW'(1) : DW'(0);
      XOR:     return a ^ b;
      OR:      return a | b;
      AND:     return a & b;
      default: return '0;
    endcase
  endfunction

  // External shared ALU.
  always_comb bus.alu_result = alu_f(bus.alu_aluop, bus.alu_opr_a, bus.alu_opr_b);

  // Requester driver state.
  bit              pv   [NR];
  aluop_t          pop  [NR];
  logic [DW-1:0]   pa   [NR];
  logic [DW-1:0]   pb   [NR];
  bit              prep [NR];
  bit              plock[NR];
  logic [NR-1:0]   rr;
  bit              rnd;

  // Reference model: pointer, and the single response slot.
  int              m_ptr, m_owner;
  bit              m_full;
  logic [DW-1:0]   m_data;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = pv[i];
      bus.req_aluop[i] = pop[i];
      bus.req_opr_a[i] = pa[i];
      bus.req_opr_b[i] = pb[i];
`ifdef ALU_ARB_LOCK_EN
      bus.req_lock[i]  = plock[i];
`endif
    end
    bus.resp_ready = rr;
  endtask

  task automatic set(input int i, input aluop_t op, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rep);
    pv[i] = 1'b1; pop[i] = op; pa[i] = a; pb[i] = b; prep[i] = rep;
  endtask

  task automatic clr();
    for (int i = 0; i < NR; i++) begin
      pv[i] = 1'b0; prep[i] = 1'b0; plock[i] = 1'b0;
    end
  endtask

  // One clock: drive, check combinational + registered outputs, advance model, return at posedge+2.
  task automatic cycle();
    int g;
    bit free;
    logic [NR-1:0] er, ev;
    apply();
    #1;
    free = !m_full || rr[m_owner];
    g = -1;
    if (!rst && free)
      for (int k = 0; k < NR; k++)
        if (g < 0 && pv[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    er = '0; if (g >= 0) er[g] = 1'b1;
    ev = '0; if (m_full) ev[m_owner] = 1'b1;
    chk("req_ready",  64'(bus.req_ready),  64'(er));
    chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
    if (m_full) chk("resp_data", 64'(bus.resp_data), 64'(m_data));
    chk("alu_aluop", 64'(bus.alu_aluop), 64'(g >= 0 ? pop[g] : ADD));
    chk("alu_opr_a", 64'(bus.alu_opr_a), 64'(g >= 0 ? pa[g] : '0));
    chk("alu_opr_b", 64'(bus.alu_opr_b), 64'(g >= 0 ? pb[g] : '0));
    if (rst) begin
      m_full = 0; m_owner = 0; m_ptr = 0; m_data = '0;
    end else if (g >= 0) begin
      m_full  = 1;
      m_owner = g;
      m_data  = alu_f(pop[g], pa[g], pb[g]);
      m_ptr   = (g + 1) % NR;
`ifdef ALU_ARB_LOCK_EN
      if (plock[g]) m_ptr = g;
`endif
      if (!prep[g]) pv[g] = 1'b0;
    end else if (m_full && rr[m_owner]) begin
      m_full = 0;
    end
    if (rnd) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i]  = 1'b1;
          pop[i] = aluop_t'($urandom_range(0, 9));
          pa[i]  = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 40));
          pb[i]  = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 40));
          prep[i] = 1'b0;
          plock[i] = ($urandom_range(0, 3) == 0);
        end
      end
      rr = NR'($urandom);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Requester hold rule: a waiting request keeps valid and its payload stable.
  for (genvar i = 0; i < NR; i++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.req_valid[i] && !bus.req_ready[i]) |=>
      (bus.req_valid[i] && $stable(bus.req_aluop[i]) && $stable(bus.req_opr_a[i]) && $stable(bus.req_opr_b[i])));
  end

  initial begin
    rst = 1'b1; rnd = 1'b0; rr = '0;
    m_ptr = 0; m_owner = 0; m_full = 0; m_data = '0;
    for (int i = 0; i < NR; i++) begin
      pop[i] = ADD; pa[i] = '0; pb[i] = '0;
    end
    clr();
    apply();
    @(posedge clk);
    #2;
    do_rst();
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_resp_data",  64'(bus.resp_data),  64'(0));

    // Single requester
    set(0, ADD, 5, 7, 0); rr = '1;
    cycle();
    chk("single_rv",   64'(bus.resp_valid), 64'(3'b001));
    chk("single_data", 64'(bus.resp_data),  64'(12));
    cycle();
    chk("single_drain", 64'(bus.resp_valid), 64'(0));

    // Contention
    clr(); do_rst();
    set(0, SUB, 10, 3, 1); set(1, XOR, 32'hF0, 32'h0F, 1); rr = '1;
    cycle();
    chk("cont_rv0", 64'(bus.resp_valid), 64'(3'b001));
    chk("cont_d0",  64'(bus.resp_data),  64'(7));
    cycle();
    chk("cont_rv1", 64'(bus.resp_valid), 64'(3'b010));
    chk("cont_d1",  64'(bus.resp_data),  64'(32'hFF));
    cycle();
    chk("cont_rv2", 64'(bus.resp_valid), 64'(3'b001));

    // Backpressure
    clr(); do_rst();
    set(0, SLT, 32'hFFFF_FFFF, 1, 0); rr = '0;
    cycle();
    chk("bp_rv", 64'(bus.resp_valid), 64'(3'b001));
    set(1, ADD, 2, 3, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold", 64'(bus.resp_data), 64'(1));
      chk("bp_rdy1", 64'(bus.req_ready), 64'(0));
    end
    rr = 3'b001;
    apply();
    #1;
    chk("bp_same_cycle", 64'(bus.req_ready), 64'(3'b010));
    cycle();
    chk("bp_rv1",   64'(bus.resp_valid), 64'(3'b010));
    chk("bp_data1", 64'(bus.resp_data),  64'(5));

    // Wrap with three requesters
    clr(); do_rst();
    for (int i = 0; i < NR; i++) set(i, ADD, DW'(i), 100, 1);
    rr = '1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("wrap_order", 64'(bus.resp_valid), 64'(1 << (k % NR)));
    end

    // Reset mid-operation
    clr(); do_rst();
    set(1, SLL, 1, 4, 0); rr = '0;
    cycle();
    chk("rmo_data", 64'(bus.resp_data), 64'(16));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rmo_rv",   64'(bus.resp_valid), 64'(0));
    chk("rmo_data0", 64'(bus.resp_data), 64'(0));
    set(1, ADD, 1, 1, 0); set(2, ADD, 2, 2, 0); rr = '1;
    cycle();
    chk("rmo_ptr0", 64'(bus.resp_valid), 64'(3'b010));

`ifdef ALU_ARB_LOCK_EN
    // Locked sequence
    clr(); do_rst();
    set(0, ADD, 1, 1, 1); plock[0] = 1'b1; set(1, ADD, 9, 9, 1); rr = '1;
    cycle(); chk("lock_g0", 64'(bus.resp_valid), 64'(3'b001));
    cycle(); chk("lock_g1", 64'(bus.resp_valid), 64'(3'b001));
    plock[0] = 1'b0;
    cycle(); chk("lock_g2", 64'(bus.resp_valid), 64'(3'b001));
    cycle(); chk("lock_rel", 64'(bus.resp_valid), 64'(3'b010));
`endif

    // Randomized traffic
    clr(); do_rst();
    rnd = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance between NUM_REQ requesters (e.g. integer pipe, address-gen, CSR/debug path) using round-robin arbitration. Each requester has a valid/ready request channel and a valid/ready response channel. The block drives the shared ALU's aluop/opr_a/opr_b and captures opr_result into a single-entry response register tagged with the winning requester.

Parameters:
DATA_WIDTH, 32, operand/result width; must match the shared alu instance.
NUM_REQ, 2, number of requesters; legal range 2..8.
IDX_W, $clog2(NUM_REQ), requester index width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester grant/accept; one-hot or zero.
req_aluop  input  NUM_REQ x alu_pkg::aluop_t  per-requester operation.
req_opr_a  input  NUM_REQ x DATA_WIDTH  per-requester operand a.
req_opr_b  input  NUM_REQ x DATA_WIDTH  per-requester operand b.
resp_valid  output  NUM_REQ  response valid, one-hot or zero, to owning requester.
resp_ready  input  NUM_REQ  per-requester response accept.
resp_data  output  DATA_WIDTH  registered result, shared bus, qualified by resp_valid.
alu_aluop  output  alu_pkg::aluop_t  to shared ALU.
alu_opr_a  output  DATA_WIDTH  to shared ALU.
alu_opr_b  output  DATA_WIDTH  to shared ALU.
alu_result  input  DATA_WIDTH  from shared ALU opr_result.

Behaviour:
- Reset (rst=1 at clk edge): resp_valid=0, resp_data=0, resp owner index=0, rr pointer=0; pending response discarded. Combinational outputs during reset: req_ready=0, alu_aluop=ADD, alu_opr_a/b=0.
- State: rr pointer (IDX_W), response slot {full, owner idx, data}. No other FSM.
- Slot free condition: free = !full | (resp_valid[owner] & resp_ready[owner]) (drain and refill in same cycle allowed).
- Arbitration (combinational): when free, grant = first i with req_valid[i]=1 searching ptr, ptr+1, ... wrapping modulo NUM_REQ. req_ready[grant]=1, all others 0. If !free or no valid, req_ready=0.
- req_ready never depends on a requester's own req_ready; it may depend on req_valid.
- ALU mux: alu_* = granted requester's aluop/opr_a/opr_b; when no grant, drive ADD/0/0 (no X propagation).
- Handshake: transfer when req_valid[i] & req_ready[i]. On transfer: slot <= {1, i, alu_result}; ptr <= (i+1) mod NUM_REQ (wrap at NUM_REQ-1 -> 0, including non-power-of-2 NUM_REQ).
- Latency: request accept at edge N -> resp_valid[i]=1 with resp_data valid from N (visible cycle N+1). Back-to-back throughput 1 op/cycle when resp_ready held high.
- Response: resp_valid[owner]=full. Held with stable resp_data until resp_ready[owner]. Drain without new transfer clears full; ptr unchanged.
- Requester rules (checked by bench assertions): once req_valid[i]=1, requester holds valid, aluop, operands stable until accepted.
- Non-owner resp_ready is ignored. Requester with no valid request never advances ptr.
- Reset mid-operation: accepted-but-undrained result lost; requesters must reissue.

Optional Feature:
ALU_ARB_LOCK_EN: adds input req_lock [NUM_REQ]. Defined: on a transfer from i with req_lock[i]=1, ptr <= i (not i+1), so i wins next arbitration if still valid, enabling atomic back-to-back sequences; a transfer with req_lock[i]=0 releases (ptr <= i+1). Undefined: port absent, ptr always advances to i+1.

Test Plan:
Single requester: req0 ADD 5+7, resp_ready0=1 -> req_ready0 same cycle, next cycle resp_valid0=1, resp_data=12, then resp_valid=0.
Contention: req0 SUB 10-3 and req1 XOR 0xF0^0x0F, both valid continuously from reset, resp_ready=11 -> grants 0 then 1; resp_data 7 then 0xFF; ptr ends at 0.
Backpressure: req0 SLT -1<1 accepted, resp_ready0=0 for 3 cycles with req1 valid -> req_ready1=0 throughout, resp_data=1 stable; on resp_ready0=1, req1 accepted same cycle.
Wrap, NUM_REQ=3: all three valid continuously -> grant order 0,1,2,0,1,2; ptr 2 -> 0.
Reset mid-op: accept req1 SLL 1<<4 (result 16), assert rst before resp_ready -> resp_valid=00 next cycle, ptr=0, no result delivered.
ALU_ARB_LOCK_EN: req0 with req_lock0=1 for 3 ADDs while req1 valid -> grants 0,0,0, then req_lock0=0 on third; next grant 1.
